id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, directly upstream of the forwarding unit and the EX stage.
- Captures decoded operands, register specifiers and control bits from ID every cycle.
- Detects load-use hazards and inserts bubbles. Honours branch flush and EX-side hold.
- Bypasses same-cycle WB writes into captured operands, so EX and the forwarding unit see correct ID_EX_Rs/Rt/Rd and data.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 5, register specifier width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ID_valid  in  1  ID holds a real instruction
- ID_Rs, ID_Rt, ID_Rd  in  REG_W  decoded specifiers
- ID_ReadData1, ID_ReadData2  in  DATA_W  register-file outputs
- ID_Imm  in  DATA_W  sign-extended immediate
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst  in  1  control
- ID_ALUOp  in  2  ALU op class
- ID_UsesRt  in  1  instruction reads Rt as a source
- Flush  in  1  branch/jump taken: kill ID instruction
- EX_Hold  in  1  EX cannot accept (multi-cycle op)
- WB_RegWrite  in  1; WB_Rd  in  REG_W; WB_Data  in  DATA_W  write-back port
- ID_EX_* outputs  out  same widths  registered copies of every ID_* field above except ID_valid and ID_UsesRt
- ID_EX_valid  out  1  registered valid
- Stall  out  1  combinational; freeze PC and IF/ID

Behaviour:
- Reset (rst=1 at posedge): all ID_EX_* outputs = 0, ID_EX_valid = 0. Reset overrides all other inputs.
- LoadUse (combinational), true when all of:
  - ID_EX_valid && ID_EX_MemRead && ID_valid
  - ID_EX_Rt != 0
  - ID_EX_Rt == ID_Rs, or (ID_UsesRt && ID_EX_Rt == ID_Rt)
- Stall = LoadUse | EX_Hold.
- Per-edge priority, highest first:
  1. rst
  2. EX_Hold: all registers keep their value. A held load still drives LoadUse.
  3. Flush: bubble.
  4. LoadUse: bubble.
  5. Otherwise: load ID fields, with ID_EX_valid = ID_valid.
- Bubble: ID_EX_valid = 0; all control bits and ALUOp = 0; Rs/Rt/Rd = 0. Data fields are don't-care but driven to 0.
- Bypass on load, per operand, applied only to the value being captured:
  - If WB_RegWrite && WB_Rd != 0 && WB_Rd == ID_Rs, capture WB_Data into ID_EX_ReadData1; else capture ID_ReadData1.
  - Same rule for ID_Rt into ID_EX_ReadData2.
  - The bypass is not applied during hold.
- Latency: one cycle from ID inputs to ID_EX_* outputs. A load-use dependency costs exactly one bubble, after which forwarding supplies the data.
- Flush and LoadUse in the same cycle: a single bubble. Stall is still asserted that cycle; the upstream stage discards on Flush.
- Register $0 is never a hazard or bypass source.

Optional Feature:
- Macro: ID_EX_BUBBLE_COUNT_EN.
- Defined:
  - Adds output BubbleCount, 32 bits.
  - Increments by 1 on each edge that inserts a bubble (Flush or LoadUse, not hold, not reset).
  - Saturates at 0xFFFFFFFF; cleared by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then load: rst for 2 cycles, then ID_valid=1, ID_Rs=8, ID_ReadData1=0x1234 -> after reset all outputs 0; one edge later ID_EX_Rs=8, ID_EX_ReadData1=0x1234, ID_EX_valid=1.
- Load-use: ID_EX holds lw with Rt=9; ID presents add with Rs=9 -> Stall=1; next edge ID_EX_valid=0 and all controls 0; following edge add captured with Stall=0. ID_UsesRt=0 with ID_Rt=9 -> no stall. ID_EX_Rt=0 -> no stall.
- Flush vs LoadUse: both active -> one bubble; with ID_EX_BUBBLE_COUNT_EN, BubbleCount increments by exactly 1.
- EX_Hold: hold for 3 cycles while ID inputs change -> ID_EX_* unchanged and Stall=1 throughout; after release, the ID value of the release cycle is captured.
- WB bypass: WB_RegWrite=1, WB_Rd=5, WB_Data=0xCAFE; ID_Rs=5, ID_Rt=5, ID_ReadData1/2=0xDEAD -> both captured as 0xCAFE. With WB_Rd=0 -> captures 0xDEAD.
- Counter saturation (macro on): force counter to 0xFFFFFFFE, insert 3 bubbles -> reads 0xFFFFFFFF; rst -> 0.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: load-use bubble insertion, flush and hold handling, and WB-to-ID operand bypass.
// Define ID_EX_BUBBLE_COUNT_EN to add the saturating BubbleCount output.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_valid,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic [REG_W-1:0]  ID_Rd,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemtoReg,
  input  logic              ID_ALUSrc,
  input  logic              ID_RegDst,
  input  logic [1:0]        ID_ALUOp,
  input  logic              ID_UsesRt,
  input  logic              Flush,
  input  logic              EX_Hold,
  input  logic              WB_RegWrite,
  input  logic [REG_W-1:0]  WB_Rd,
  input  logic [DATA_W-1:0] WB_Data,
  output logic [REG_W-1:0]  ID_EX_Rs,
  output logic [REG_W-1:0]  ID_EX_Rt,
  output logic [REG_W-1:0]  ID_EX_Rd,
  output logic [DATA_W-1:0] ID_EX_ReadData1,
  output logic [DATA_W-1:0] ID_EX_ReadData2,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_MemtoReg,
  output logic              ID_EX_ALUSrc,
  output logic              ID_EX_RegDst,
  output logic [1:0]        ID_EX_ALUOp,
  output logic              ID_EX_valid,
`ifdef ID_EX_BUBBLE_COUNT_EN
  output logic [31:0]       BubbleCount,
`endif
  output logic              Stall
);

  logic [REG_W-1:0]  r_rs, r_rt, r_rd;
  logic [DATA_W-1:0] r_readData1, r_readData2, r_imm;
  logic              r_regWrite, r_memRead, r_memWrite, r_memtoReg, r_aluSrc, r_regDst;
  logic [1:0]        r_aluOp;
  logic              r_valid;

  logic              w_loadUse;
  logic              w_bubble;
  logic              w_bypass1;
  logic              w_bypass2;

  // A held load stays in r_* and therefore keeps asserting the load-use check.
  assign w_loadUse = r_valid && r_memRead && ID_valid && (r_rt != '0) &&
                     ((r_rt == ID_Rs) || (ID_UsesRt && (r_rt == ID_Rt)));
  assign Stall     = w_loadUse | EX_Hold;
  assign w_bubble  = !EX_Hold && (Flush || w_loadUse);

  assign w_bypass1 = WB_RegWrite && (WB_Rd != '0) && (WB_Rd == ID_Rs);
  assign w_bypass2 = WB_RegWrite && (WB_Rd != '0) && (WB_Rd == ID_Rt);

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_readData1 <= '0;
      r_readData2 <= '0;
      r_imm       <= '0;
      r_regWrite  <= 1'b0;
      r_memRead   <= 1'b0;
      r_memWrite  <= 1'b0;
      r_memtoReg  <= 1'b0;
      r_aluSrc    <= 1'b0;
      r_regDst    <= 1'b0;
      r_aluOp     <= 2'b00;
      r_valid     <= 1'b0;
    end else if (!EX_Hold) begin
      r_rs        <= ID_Rs;
      r_rt        <= ID_Rt;
      r_rd        <= ID_Rd;
      r_readData1 <= w_bypass1 ? WB_Data : ID_ReadData1;
      r_readData2 <= w_bypass2 ? WB_Data : ID_ReadData2;
      r_imm       <= ID_Imm;
      r_regWrite  <= ID_RegWrite;
      r_memRead   <= ID_MemRead;
      r_memWrite  <= ID_MemWrite;
      r_memtoReg  <= ID_MemtoReg;
      r_aluSrc    <= ID_ALUSrc;
      r_regDst    <= ID_RegDst;
      r_aluOp     <= ID_ALUOp;
      r_valid     <= ID_valid;
    end
  end

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [31:0] r_bubbleCount;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubbleCount <= '0;
    end else if (w_bubble && (r_bubbleCount != 32'hFFFF_FFFF)) begin
      r_bubbleCount <= r_bubbleCount + 32'd1;
    end
  end

  assign BubbleCount = r_bubbleCount;
`endif

  assign ID_EX_Rs        = r_rs;
  assign ID_EX_Rt        = r_rt;
  assign ID_EX_Rd        = r_rd;
  assign ID_EX_ReadData1 = r_readData1;
  assign ID_EX_ReadData2 = r_readData2;
  assign ID_EX_Imm       = r_imm;
  assign ID_EX_RegWrite  = r_regWrite;
  assign ID_EX_MemRead   = r_memRead;
  assign ID_EX_MemWrite  = r_memWrite;
  assign ID_EX_MemtoReg  = r_memtoReg;
  assign ID_EX_ALUSrc    = r_aluSrc;
  assign ID_EX_RegDst    = r_regDst;
  assign ID_EX_ALUOp     = r_aluOp;
  assign ID_EX_valid     = r_valid;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios plus randomized traffic against a behavioural model.
// Counter checks are compiled only when ID_EX_BUBBLE_COUNT_EN is defined.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        idValid;
  logic [4:0]  idRs, idRt, idRd;
  logic [31:0] idRd1, idRd2, idImm;
  logic        idRegWrite, idMemRead, idMemWrite, idMemtoReg, idAluSrc, idRegDst;
  logic [1:0]  idAluOp;
  logic        idUsesRt, flush, exHold;
  logic        wbRegWrite;
  logic [4:0]  wbRd;
  logic [31:0] wbData;

  logic [4:0]  exRs, exRt, exRd;
  logic [31:0] exRd1, exRd2, exImm;
  logic        exRegWrite, exMemRead, exMemWrite, exMemtoReg, exAluSrc, exRegDst;
  logic [1:0]  exAluOp;
  logic        exValid, stall;
`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [31:0] bubbleCount;
`endif

  int checks = 0;
  int failures = 0;

  // Expected contents of the ID/EX register, as seen by EX.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic [5:0]  ctrl;
    logic [1:0]  aluOp;
  } stageT;

  stageT       expStage;
  int unsigned expCount;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .ID_valid(idValid),
    .ID_Rs(idRs), .ID_Rt(idRt), .ID_Rd(idRd),
    .ID_ReadData1(idRd1), .ID_ReadData2(idRd2), .ID_Imm(idImm),
    .ID_RegWrite(idRegWrite), .ID_MemRead(idMemRead), .ID_MemWrite(idMemWrite),
    .ID_MemtoReg(idMemtoReg), .ID_ALUSrc(idAluSrc), .ID_RegDst(idRegDst),
    .ID_ALUOp(idAluOp), .ID_UsesRt(idUsesRt), .Flush(flush), .EX_Hold(exHold),
    .WB_RegWrite(wbRegWrite), .WB_Rd(wbRd), .WB_Data(wbData),
    .ID_EX_Rs(exRs), .ID_EX_Rt(exRt), .ID_EX_Rd(exRd),
    .ID_EX_ReadData1(exRd1), .ID_EX_ReadData2(exRd2), .ID_EX_Imm(exImm),
    .ID_EX_RegWrite(exRegWrite), .ID_EX_MemRead(exMemRead), .ID_EX_MemWrite(exMemWrite),
    .ID_EX_MemtoReg(exMemtoReg), .ID_EX_ALUSrc(exAluSrc), .ID_EX_RegDst(exRegDst),
    .ID_EX_ALUOp(exAluOp), .ID_EX_valid(exValid),
`ifdef ID_EX_BUBBLE_COUNT_EN
    .BubbleCount(bubbleCount),
`endif
    .Stall(stall)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // A later instruction must wait if it reads the register an in-flight load is about to produce.
  function automatic logic modelHazard();
    if (!(expStage.valid && expStage.ctrl[4] && idValid)) return 1'b0;
    if (expStage.rt == 5'd0) return 1'b0;
    return (expStage.rt == idRs) || (idUsesRt && (expStage.rt == idRt));
  endfunction

  function automatic logic [31:0] modelOperand(input logic [4:0] src, input logic [31:0] fileValue);
    if (wbRegWrite && wbRd != 5'd0 && wbRd == src) return wbData;
    return fileValue;
  endfunction

  task automatic setIdle();
    rst = 0; idValid = 0; idRs = 0; idRt = 0; idRd = 0;
    idRd1 = 0; idRd2 = 0; idImm = 0;
    {idRegWrite, idMemRead, idMemWrite, idMemtoReg, idAluSrc, idRegDst} = '0;
    idAluOp = 0; idUsesRt = 0; flush = 0; exHold = 0;
    wbRegWrite = 0; wbRd = 0; wbData = 0;
  endtask

  // Random traffic with a tiny register range so hazards and bypasses collide often.
  task automatic applyStimulus();
    rst        = ($urandom_range(0, 49) == 0);
    idValid    = ($urandom_range(0, 9) != 0);
    idRs       = 5'($urandom_range(0, 3));
    idRt       = 5'($urandom_range(0, 3));
    idRd       = 5'($urandom_range(0, 31));
    idRd1      = $urandom;
    idRd2      = $urandom;
    idImm      = $urandom;
    {idRegWrite, idMemWrite, idMemtoReg, idAluSrc, idRegDst} = 5'($urandom);
    idMemRead  = ($urandom_range(0, 2) == 0);
    idAluOp    = 2'($urandom);
    idUsesRt   = 1'($urandom);
    flush      = ($urandom_range(0, 9) == 0);
    exHold     = ($urandom_range(0, 6) == 0);
    wbRegWrite = 1'($urandom);
    wbRd       = 5'($urandom_range(0, 3));
    wbData     = $urandom;
  endtask

  // Called just after a falling edge with inputs already driven; returns just after the next falling edge.
  task automatic runCycle();
    stageT next;
    logic  hazard;
    #1;
    hazard = modelHazard();
    checkOutput("stall", 64'(stall), 64'(hazard | exHold));
    next = expStage;
    if (rst) begin
      next = '0;
      expCount = 0;
    end else if (exHold) begin
      next = expStage;
    end else if (flush || hazard) begin
      next = '0;
      if (expCount != 32'hFFFF_FFFF) expCount++;
    end else begin
      next.valid = idValid;
      next.rs = idRs; next.rt = idRt; next.rd = idRd;
      next.d1 = modelOperand(idRs, idRd1);
      next.d2 = modelOperand(idRt, idRd2);
      next.imm = idImm;
      next.ctrl = {idRegWrite, idMemRead, idMemWrite, idMemtoReg, idAluSrc, idRegDst};
      next.aluOp = idAluOp;
    end
    @(posedge clk);
    #1;
    expStage = next;
    checkOutput("valid", 64'(exValid), 64'(expStage.valid));
    checkOutput("regs", 64'({exRs, exRt, exRd}), 64'({expStage.rs, expStage.rt, expStage.rd}));
    checkOutput("ctrl", 64'({exRegWrite, exMemRead, exMemWrite, exMemtoReg, exAluSrc, exRegDst, exAluOp}),
                64'({expStage.ctrl, expStage.aluOp}));
    checkOutput("data1", 64'(exRd1), 64'(expStage.d1));
    checkOutput("data2", 64'(exRd2), 64'(expStage.d2));
    checkOutput("imm", 64'(exImm), 64'(expStage.imm));
`ifdef ID_EX_BUBBLE_COUNT_EN
    checkOutput("bubbleCount", 64'(bubbleCount), 64'(expCount));
`endif
    @(negedge clk);
  endtask

  task automatic issueLoad(input logic [4:0] rt);
    setIdle();
    idValid = 1; idMemRead = 1; idRegWrite = 1; idMemtoReg = 1; idAluSrc = 1; idRt = rt;
    runCycle();
  endtask

  initial begin
    stageT       snap;
    int unsigned countBefore;
    expStage = '0;
    expCount = 0;
    setIdle();
    @(negedge clk);

    // Reset for two cycles, then a simple capture.
    rst = 1;
    runCycle();
    runCycle();
    checkOutput("resetValid", 64'(exValid), 64'd0);
    setIdle();
    idValid = 1; idRs = 8; idRd1 = 32'h1234;
    runCycle();
    checkOutput("loadRs", 64'(exRs), 64'd8);
    checkOutput("loadData1", 64'(exRd1), 64'h1234);
    checkOutput("loadValid", 64'(exValid), 64'd1);

    // Load followed by a dependent add costs exactly one bubble.
    issueLoad(5'd9);
    setIdle();
    idValid = 1; idRs = 9; idRd = 10; idRegWrite = 1; idAluOp = 2'b10;
    #1 checkOutput("luStall", 64'(stall), 64'd1);
    runCycle();
    checkOutput("luBubbleValid", 64'(exValid), 64'd0);
    checkOutput("luBubbleCtrl", 64'({exRegWrite, exMemRead, exAluOp}), 64'd0);
    #1 checkOutput("luStallReleased", 64'(stall), 64'd0);
    runCycle();
    checkOutput("luAddCaptured", 64'({exValid, exRs}), 64'({1'b1, 5'd9}));

    // Rt match without an Rt read, and a load targeting $0, never stall.
    issueLoad(5'd9);
    setIdle();
    idValid = 1; idRs = 1; idRt = 9; idUsesRt = 0;
    #1 checkOutput("noUsesRtStall", 64'(stall), 64'd0);
    runCycle();
    issueLoad(5'd0);
    setIdle();
    idValid = 1; idRs = 0; idRt = 0; idUsesRt = 1;
    #1 checkOutput("zeroRtStall", 64'(stall), 64'd0);
    runCycle();

    // Flush coinciding with load-use gives a single bubble.
    issueLoad(5'd9);
    setIdle();
    idValid = 1; idRs = 9; flush = 1;
    countBefore = expCount;
    #1 checkOutput("flushLuStall", 64'(stall), 64'd1);
    runCycle();
    checkOutput("flushLuValid", 64'(exValid), 64'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
    checkOutput("flushLuCount", 64'(bubbleCount), 64'(countBefore + 1));
`endif

    // Three-cycle hold with changing ID inputs, then capture on release.
    setIdle();
    idValid = 1; idRs = 3; idRt = 4; idRd = 5; idRd1 = 32'h55; idRegWrite = 1;
    runCycle();
    snap = expStage;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      rst = 0; exHold = 1;
      runCycle();
      checkOutput("holdRegs", 64'({exValid, exRs, exRt, exRd, exRd1}),
                  64'({snap.valid, snap.rs, snap.rt, snap.rd, snap.d1}));
    end
    setIdle();
    idValid = 1; idRs = 7; idRd1 = 32'h77;
    runCycle();
    checkOutput("holdRelease", 64'({exRs, exRd1}), 64'({5'd7, 32'h77}));

    // Same-cycle write-back reaches both captured operands; $0 never bypasses.
    setIdle();
    idValid = 1; idRs = 5; idRt = 5; idRd1 = 32'hDEAD; idRd2 = 32'hDEAD;
    wbRegWrite = 1; wbRd = 5; wbData = 32'hCAFE;
    runCycle();
    checkOutput("bypass", 64'({exRd1, exRd2}), {32'hCAFE, 32'hCAFE});
    wbRd = 0; idRs = 0; idRt = 0;
    runCycle();
    checkOutput("noBypassZero", 64'({exRd1, exRd2}), {32'hDEAD, 32'hDEAD});

`ifdef ID_EX_BUBBLE_COUNT_EN
    // Counter saturation near the top of its range.
    force dut.r_bubbleCount = 32'hFFFF_FFFE;
    #1 release dut.r_bubbleCount;
    expCount = 32'hFFFF_FFFE;
    setIdle();
    flush = 1;
    for (int i = 0; i < 3; i++) runCycle();
    checkOutput("countSaturated", 64'(bubbleCount), 64'hFFFF_FFFF);
    setIdle();
    rst = 1;
    runCycle();
    checkOutput("countCleared", 64'(bubbleCount), 64'd0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus();
      runCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
